entropy_symbol_encoder: RTL and testbench
=========================================

Name: entropy_symbol_encoder

Overview:
Encoder-side counterpart of the JPEG entropy decode path. Accepts one quantized 8x8 block (natural row-major order) per handshake and applies the zigzag scan and per-channel DC differencing. Emits a stream of JPEG run/size/amplitude symbols (DC, AC, ZRL, EOB) over a valid/ready interface for a downstream Huffman coder and bit packer. Symbols are bit-exact with what the decoder-side VLI/diff/block-buffer path consumes.

Parameters:
CH, 3, number of colour channels, each with its own DC predictor
CH_W, $clog2(CH+1), channel id width

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
blk_valid  in  1  block offered
blk_ready  out  1  block accepted when blk_valid && blk_ready
blk_in  in  64x12 signed  coefficients; index r*8+c = row r, col c
blk_ch  in  CH_W  channel of offered block
dc_clear  in  1  zero all DC predictors (restart interval)
sym_valid  out  1  symbol present
sym_ready  in  1  downstream takes symbol
sym_dc  out  1  symbol is DC
sym_run  out  4  zero run (AC), 0 for DC
sym_size  out  4  VLI category 0..11
sym_amp  out  11  VLI amplitude bits, right-aligned, upper bits 0
sym_ch  out  CH_W  channel of current block
sym_last  out  1  final symbol of block

Behaviour:
- Reset: blk_ready=0 on the reset cycle, then 1 (IDLE). All sym_* outputs = 0. All predictors = 0. Reset mid-block aborts the block and emits nothing further.
- FSM states: IDLE, DC, AC, EOB.
- IDLE: blk_ready=1. On handshake:
  - Capture blk_in into a 64-entry register, reordered into zigzag order, with z[0]=DC.
  - Latch blk_ch.
  - Compute diff = z[0] - pred[ch], modulo 2^12 (12-bit wrap).
  - Write pred[ch] <= z[0].
  - Go to DC.
- blk_ready is 0 in every state except IDLE.
- DC: sym_valid=1, sym_dc=1, run=0, size/amp from diff. Next cycle after acceptance is the earliest the DC symbol is valid. On sym_ready:
  - if last_nz==0, go to EOB;
  - else go to AC with k=1, run=0.
- last_nz: highest zigzag index 1..63 with a nonzero coefficient, or 0 if none. Computed combinationally from the captured register.
- AC, one step per cycle while no symbol is pending:
  - z[k]==0 and k<last_nz: run++, k++, no output.
  - z[k]!=0 and run>=16: present ZRL (run=15, size=0, amp=0). On handshake, run -= 16 and k is unchanged.
  - z[k]!=0 and run<16: present (run, size, amp). On handshake, run=0 and k++.
  - After the handshake at k==last_nz: if last_nz==63, sym_last=1 on that symbol and go to IDLE; else go to EOB.
  - ZRLs are never emitted for trailing zeros.
- EOB: present run=0, size=0, amp=0, sym_dc=0, sym_last=1. On handshake go to IDLE.
- Size/amp rule for 12-bit signed v:
  - size = bit length of |v|; size 0 iff v==0.
  - v>0: amp = v.
  - v<0: amp = low size bits of (v-1), i.e. one's complement.
  - v=-2048 gives size 11, amp 0x000 (wrapped).
- Output hold: all sym_* fields are stable while sym_valid && !sym_ready. Scanning stalls during backpressure.
- dc_clear:
  - Zeroes all predictors in the same cycle.
  - If asserted on a block-accept cycle, that block's diff uses pred=0, and the predictor write of the new DC takes priority over the clear.
- blk_ch >= CH: diff uses pred 0 and no predictor is written.
- Throughput: at most one symbol per cycle. Zero coefficients cost one cycle each.

Optional Feature:
Macro ENTROPY_ENC_STATS_EN.
- Defined: adds outputs stat_nz (7 bits, count of nonzero AC coefficients in the last completed block) and stat_zrl (3 bits, ZRLs emitted in that block). Both update on the sym_last handshake and reset to 0.
- Undefined: neither port nor counter logic exists. Behaviour is otherwise identical.

Test Plan:
- All-zero block, ch0, after reset -> exactly two symbols: DC(size0, amp0), then EOB with sym_last=1. blk_ready returns high the cycle after the EOB handshake.
- Two ch0 blocks with DC=5 then DC=3, all AC zero -> DC symbols (size3, amp 101b) then (size2, amp 01b) for diff -2, each followed by EOB.
- Zigzag index 1 = -1, index 20 = 7, rest 0, sym_ready always 1 -> symbols: DC, AC(run0, size1, amp0), AC(run18→ZRL first: run15/size0), AC(run2, size3, amp 111b), EOB.
- Zigzag index 63 = 1 only -> DC, 3 ZRLs, AC(run14, size1, amp1) with sym_last=1, no EOB.
- sym_ready toggled randomly, plus dc_clear mid-stream between blocks -> symbol sequence identical to the no-stall run. The DC diff after the clear equals the raw DC. Outputs are stable during stalls.
- rst asserted during AC emission -> the next cycle has sym_valid=0 and all predictors 0. The next block's DC diff equals the raw DC.

Source files
------------

// File: rtl/entropy_symbol_encoder.sv
// JPEG entropy symbol encoder: zigzag scan, per-channel DC differencing, run/size/amp symbol stream.
// Optional block statistics outputs (stat_nz, stat_zrl) are enabled by defining ENTROPY_ENC_STATS_EN.
module entropy_symbol_encoder #(
  parameter int CH   = 3,
  parameter int CH_W = $clog2(CH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [63:0][11:0]     blk_in,
  input  logic [CH_W-1:0]       blk_ch,
  input  logic                  dc_clear,
  output logic                  sym_valid,
  input  logic                  sym_ready,
  output logic                  sym_dc,
  output logic [3:0]            sym_run,
  output logic [3:0]            sym_size,
  output logic [10:0]           sym_amp,
  output logic [CH_W-1:0]       sym_ch,
  output logic                  sym_last
`ifdef ENTROPY_ENC_STATS_EN
  ,
  output logic [6:0]            stat_nz,
  output logic [2:0]            stat_zrl
`endif
);

  typedef enum logic [1:0] {IDLE, DC, AC, EOB} state_t;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};

  // {size, amp}; -2048 is folded onto size 11 / amp 0 to stay within the 11-bit field
  function automatic logic [14:0] vli(input logic [11:0] v);
    logic [11:0] mag;
    logic [3:0]  sz;
    logic [10:0] amp;
    mag = v[11] ? (12'd0 - v) : v;
    sz  = 4'd0;
    for (int i = 0; i < 12; i++) if (mag[i]) sz = 4'(i + 1);
    if (v == 12'h800) begin
      sz  = 4'd11;
      amp = 11'd0;
    end else if (v[11]) amp = (v[10:0] - 11'd1) & ((11'd1 << sz) - 11'd1);
    else                amp = v[10:0];
    return {sz, amp};
  endfunction

  state_t           state, nstate;
  logic [63:0][11:0] z;
  logic [CH_W-1:0]  ch_q;
  logic [11:0]      diff;
  logic [11:0]      pred [CH];
  logic [11:0]      pred_sel;
  logic [5:0]       k, nk, run, nrun, last_nz;
  logic [11:0]      cur;
  logic             accept;

  assign accept = blk_valid && blk_ready;
  assign cur    = z[k];

  always_comb begin
    last_nz = 6'd0;
    for (int i = 1; i < 64; i++) if (z[i] != 12'd0) last_nz = 6'(i);
  end

  // Out-of-range channels and a same-cycle clear both predict from zero
  always_comb begin
    pred_sel = 12'd0;
    for (int i = 0; i < CH; i++)
      if (blk_ch == CH_W'(i) && !dc_clear) pred_sel = pred[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) pred[i] <= 12'd0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (dc_clear) pred[i] <= 12'd0;
        if (accept && blk_ch == CH_W'(i)) pred[i] <= blk_in[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 64; i++) z[i] <= blk_in[ZZ[i]];
      ch_q <= blk_ch;
      diff <= blk_in[0] - pred_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= 6'd0;
      run   <= 6'd0;
    end else begin
      state <= nstate;
      k     <= nk;
      run   <= nrun;
    end
  end

  always_comb begin
    nstate    = state;
    nk        = k;
    nrun      = run;
    blk_ready = 1'b0;
    sym_valid = 1'b0;
    sym_dc    = 1'b0;
    sym_run   = 4'd0;
    sym_size  = 4'd0;
    sym_amp   = 11'd0;
    sym_ch    = '0;
    sym_last  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          blk_ready = 1'b1;
          if (blk_valid) nstate = DC;
        end
        DC: begin
          sym_valid           = 1'b1;
          sym_dc              = 1'b1;
          sym_ch              = ch_q;
          {sym_size, sym_amp} = vli(diff);
          if (sym_ready) begin
            nstate = (last_nz == 6'd0) ? EOB : AC;
            nk     = 6'd1;
            nrun   = 6'd0;
          end
        end
        AC: begin
          sym_ch = ch_q;
          // k never passes last_nz, so a zero here is always an interior zero
          if (cur == 12'd0) begin
            nrun = run + 6'd1;
            nk   = k + 6'd1;
          end else if (run >= 6'd16) begin
            sym_valid = 1'b1;
            sym_run   = 4'd15;
            if (sym_ready) nrun = run - 6'd16;
          end else begin
            sym_valid           = 1'b1;
            sym_run             = run[3:0];
            {sym_size, sym_amp} = vli(cur);
            sym_last            = (k == 6'd63);
            if (sym_ready) begin
              nrun = 6'd0;
              nk   = k + 6'd1;
              if (k == last_nz) nstate = (k == 6'd63) ? IDLE : EOB;
            end
          end
        end
        EOB: begin
          sym_valid = 1'b1;
          sym_last  = 1'b1;
          sym_ch    = ch_q;
          if (sym_ready) nstate = IDLE;
        end
        default: nstate = IDLE;
      endcase
    end
  end

`ifdef ENTROPY_ENC_STATS_EN
  logic [6:0] nz_cnt;
  logic [2:0] zrl_cnt;
  logic       hs_ac, is_zrl;
  assign hs_ac  = sym_valid && sym_ready && state == AC;
  assign is_zrl = sym_size == 4'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      nz_cnt   <= 7'd0;
      zrl_cnt  <= 3'd0;
      stat_nz  <= 7'd0;
      stat_zrl <= 3'd0;
    end else begin
      if (accept) begin
        nz_cnt  <= 7'd0;
        zrl_cnt <= 3'd0;
      end else if (hs_ac) begin
        if (is_zrl) zrl_cnt <= zrl_cnt + 3'd1;
        else        nz_cnt  <= nz_cnt + 7'd1;
      end
      if (sym_valid && sym_ready && sym_last) begin
        stat_nz  <= nz_cnt + 7'(hs_ac && !is_zrl);
        stat_zrl <= zrl_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_entropy_symbol_encoder.sv
// Scoreboard bench for entropy_symbol_encoder: directed blocks, hand-computed symbol lists.
module tb_entropy_symbol_encoder;
  localparam int CH = 3, CH_W = 2;

  logic                clk = 1'b0;
  logic                rst, blk_valid, blk_ready, dc_clear;
  logic [63:0][11:0]   blk_in;
  logic [CH_W-1:0]     blk_ch, sym_ch;
  logic                sym_valid, sym_ready, sym_dc, sym_last;
  logic [3:0]          sym_run, sym_size;
  logic [10:0]         sym_amp;
`ifdef ENTROPY_ENC_STATS_EN
  logic [6:0]          stat_nz;
  logic [2:0]          stat_zrl;
`endif

  entropy_symbol_encoder #(.CH(CH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_in(blk_in), .blk_ch(blk_ch), .dc_clear(dc_clear),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_dc(sym_dc),
    .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
    .sym_ch(sym_ch), .sym_last(sym_last)
`ifdef ENTROPY_ENC_STATS_EN
    , .stat_nz(stat_nz), .stat_zrl(stat_zrl)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dc;
    logic [3:0]  run;
    logic [3:0]  size;
    logic [10:0] amp;
    logic [1:0]  ch;
    logic        last;
  } sym_t;

  int zz_tab [64] = '{
    0,  1,  8,  16, 9,  2,  3,  10, 17, 24, 32, 25, 18, 11, 4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6,  7,  14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  sym_t q[$];
  int   errors = 0, checks = 0;
  bit   mon_en = 1'b0, rdy_rand = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit dc, input int run, input int size, input int amp,
                      input int ch, input bit last);
    q.push_back({dc, 4'(run), 4'(size), 11'(amp), 2'(ch), last});
  endtask

  always @(posedge clk) begin
    #1;
    sym_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops on every handshake and checks fields hold through stalls
  sym_t cur_s, held_s, exp_s;
  bit   stalled = 1'b0;
  always @(negedge clk) begin
    cur_s = {sym_dc, sym_run, sym_size, sym_amp, sym_ch, sym_last};
    if (mon_en && !rst) begin
      if (stalled) chk("hold", int'(cur_s), int'(held_s));
      if (sym_valid && sym_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sym: got %0h expected none", cur_s);
        end else begin
          exp_s = q.pop_front();
          chk("sym", int'(cur_s), int'(exp_s));
        end
      end
      stalled = sym_valid && !sym_ready;
      held_s  = cur_s;
    end else stalled = 1'b0;
  end

  task automatic send(input logic [63:0][11:0] zv, input int ch, input bit clr);
    logic [63:0][11:0] nat;
    int n;
    for (int i = 0; i < 64; i++) nat[zz_tab[i]] = zv[i];
    @(posedge clk); #1;
    blk_in = nat; blk_ch = 2'(ch); dc_clear = clr; blk_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!blk_ready && n < 500);
    if (!blk_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got blk_ready=0 expected 1");
    end
    @(posedge clk); #1;
    blk_valid = 1'b0; dc_clear = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    q.delete();
    @(negedge clk);
    chk("blk_ready_idle", int'(blk_ready), 1);
  endtask

  logic [63:0][11:0] v;

  initial begin
    rst = 1'b1; blk_valid = 1'b0; dc_clear = 1'b0; blk_ch = '0; blk_in = '0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_blk_ready", int'(blk_ready), 0);
    chk("rst_sym_valid", int'(sym_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_blk_ready", int'(blk_ready), 1);
    chk("post_rst_sym_valid", int'(sym_valid), 0);

    // all-zero block
    v = '0;
    push(1, 0, 0, 0, 0, 0); push(0, 0, 0, 0, 0, 1);
    send(v, 0, 0); drain();

    // DC 5 then 3 on ch0: diffs 5 and -2
    v = '0; v[0] = 12'd5;
    push(1, 0, 3, 5, 0, 0); push(0, 0, 0, 0, 0, 1);
    send(v, 0, 0); drain();
    v[0] = 12'd3;
    push(1, 0, 2, 1, 0, 0); push(0, 0, 0, 0, 0, 1);
    send(v, 0, 0); drain();

    // z1=-1, z20=7 on ch1: run of 18 splits into ZRL + run 2
    v = '0; v[1] = 12'hFFF; v[20] = 12'd7;
    push(1, 0, 0, 0, 1, 0); push(0, 0, 1, 0, 1, 0); push(0, 15, 0, 0, 1, 0);
    push(0, 2, 3, 7, 1, 0); push(0, 0, 0, 0, 1, 1);
    send(v, 1, 0); drain();

    // DC -2048 on ch2, z63=1: three ZRLs then last AC, no EOB
    v = '0; v[0] = 12'h800; v[63] = 12'd1;
    push(1, 0, 11, 0, 2, 0);
    for (int i = 0; i < 3; i++) push(0, 15, 0, 0, 2, 0);
    push(0, 14, 1, 1, 2, 1);
    send(v, 2, 0); drain();

    // random backpressure from here on
    rdy_rand = 1'b1;
    v = '0; v[0] = 12'd100; v[1] = 12'hFFF; v[20] = 12'd7;
    push(1, 0, 7, 100, 1, 0); push(0, 0, 1, 0, 1, 0); push(0, 15, 0, 0, 1, 0);
    push(0, 2, 3, 7, 1, 0); push(0, 0, 0, 0, 1, 1);
    send(v, 1, 0); drain();

    // clear on accept: diff = raw DC, then predictor holds the new DC
    v = '0; v[0] = 12'd50; v[5] = 12'd2047; v[6] = 12'hFFB;
    push(1, 0, 6, 50, 0, 0); push(0, 4, 11, 11'h7FF, 0, 0); push(0, 0, 3, 2, 0, 0);
    push(0, 0, 0, 0, 0, 1);
    send(v, 0, 1); drain();
    v = '0; v[0] = 12'd60;
    push(1, 0, 4, 10, 0, 0); push(0, 0, 0, 0, 0, 1);
    send(v, 0, 0); drain();

    // channel out of range: no predictor, so same diff twice
    v = '0; v[0] = 12'd9;
    for (int i = 0; i < 2; i++) begin
      push(1, 0, 4, 9, 3, 0); push(0, 0, 0, 0, 3, 1);
      send(v, 3, 0); drain();
    end

    // standalone clear between blocks
    @(posedge clk); #1 dc_clear = 1'b1;
    @(posedge clk); #1 dc_clear = 1'b0;
    v = '0; v[0] = 12'hFF9;
    push(1, 0, 3, 0, 0, 0); push(0, 0, 0, 0, 0, 1);
    send(v, 0, 0); drain();

    // reset while scanning AC zeros
    rdy_rand = 1'b0;
    mon_en = 1'b0;
    v = '0; v[0] = 12'd20; v[63] = 12'd1;
    send(v, 1, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sym_valid", int'(sym_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("after_rst_sym_valid", int'(sym_valid), 0);
    chk("after_rst_blk_ready", int'(blk_ready), 1);
    q.delete();
    mon_en = 1'b1;
    v = '0; v[0] = 12'd20;
    push(1, 0, 5, 20, 1, 0); push(0, 0, 0, 0, 1, 1);
    send(v, 1, 0); drain();
    v = '0; v[0] = 12'hFFF;
    push(1, 0, 1, 0, 0, 0); push(0, 0, 0, 0, 0, 1);
    send(v, 0, 0); drain();
    v = '0; v[0] = 12'd3;
    push(1, 0, 2, 3, 2, 0); push(0, 0, 0, 0, 2, 1);
    send(v, 2, 0); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
